key_port: RTL

KEY_PORT -- requirements
Module: key_port

---
 rtl/tester_pkg.sv | 24 ++
 rtl/key_debounce.sv | 83 ++++++++
 rtl/key_port.sv | 91 +++++++++
 3 files changed

// File: rtl/tester_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tester_pkg
// Description : Shared defaults and helpers for the key_port debouncer.
//               Holds the default channel count, the default debounce
//               length, and the function that sizes the debounce counter.
// Revision    : 1.0 - initial release
// ============================================================================
package tester_pkg;

    // Default number of key/switch channels.
    localparam int N_KEYS_DEF    = 6;

    // Default debounce length: 1 ms of stable input at 50 MHz.
    localparam int DB_CYCLES_DEF = 50000;

    // Debounce counter width: clog2(DB_CYCLES) + 1.
    function automatic int db_cnt_width(input int db_cycles);
        return $clog2(db_cycles) + 1;
    endfunction

endpackage : tester_pkg
`default_nettype wire

// File: rtl/key_debounce.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : One key channel. Two-flop synchronizer, polarity
//               normalization to 1 = pressed, and a debounce counter that
//               accepts a level change after DB_CYCLES consecutive samples
//               that differ from the current debounced state.
// Ports       : in_clk     - system clock, rising edge
//               in_arst_n  - raw asynchronous reset (synchronizer only)
//               in_rst_n   - internally synchronized reset (counter/state)
//               key_pin    - raw asynchronous key pin
//               key_state  - debounced level, 1 = pressed
//               key_accept - 1 in the cycle whose edge toggles key_state
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce
    import tester_pkg::*;
#(
    parameter int DB_CYCLES  = DB_CYCLES_DEF,
    parameter int ACTIVE_LOW = 1
) (
    input  logic in_clk,
    input  logic in_arst_n,
    input  logic in_rst_n,
    input  logic key_pin,
    output logic key_state,
    output logic key_accept
);

    localparam int              CNT_W     = db_cnt_width(DB_CYCLES);
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DB_CYCLES - 1);
    // Released pin level: what the synchronizer holds during reset.
    localparam logic            C_IDLE    = (ACTIVE_LOW != 0);

    logic [1:0]       sync_d,  sync_q;
    logic [CNT_W-1:0] cnt_d,   cnt_q;
    logic             state_d, state_q;
    logic             sample;

    // The synchronizer is reset by the raw reset so that it starts
    // sampling on the first edge after reset release, in parallel with
    // the reset deassertion synchronizer. A metastable release here is
    // harmless: these flops already resolve an asynchronous input.
    always_ff @(posedge in_clk or negedge in_arst_n) begin
        if (!in_arst_n) begin
            sync_q <= {2{C_IDLE}};
        end else begin
            sync_q <= sync_d;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            cnt_q   <= '0;
            state_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        sync_d     = {sync_q[0], key_pin};
        sample     = (ACTIVE_LOW != 0) ? ~sync_q[1] : sync_q[1];
        cnt_d      = '0;
        state_d    = state_q;
        key_accept = 1'b0;
        if (sample != state_q) begin
            if (cnt_q == C_CNT_MAX) begin
                // Stable long enough: accept, restart the counter.
                state_d    = ~state_q;
                key_accept = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign key_state = state_q;

endmodule : key_debounce
`default_nettype wire

// File: rtl/key_port.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : key_port
// Description : N_KEYS-channel debounced key port with sticky press/release
//               event flags, masked clear, and an interrupt output.
// Ports       : in_clk      - system clock, rising edge
//               in_rst      - async-assert, active-low reset
//               key_in      - raw key pins
//               in_clr      - clear strobe for event flags
//               in_clr_mask - per-channel select for in_clr
//               key_state   - debounced level, 1 = pressed
//               key_press   - sticky press flags
//               key_release - sticky release flags
//               out_irq     - OR of all flags
// Revision    : 1.0 - initial release
// ============================================================================
module key_port
    import tester_pkg::*;
#(
    parameter int N_KEYS     = N_KEYS_DEF,
    parameter int DB_CYCLES  = DB_CYCLES_DEF,
    parameter int ACTIVE_LOW = 1
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic [N_KEYS-1:0] key_in,
    input  logic              in_clr,
    input  logic [N_KEYS-1:0] in_clr_mask,
    output logic [N_KEYS-1:0] key_state,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic              out_irq
);

    logic [1:0]        rst_sync_q;
    logic              rst_n;
    logic [N_KEYS-1:0] accept;
    logic [N_KEYS-1:0] press_d,   press_q;
    logic [N_KEYS-1:0] release_d, release_q;
    logic [N_KEYS-1:0] clr_sel;

    // Reset deassertion synchronizer: asserts immediately, releases on the
    // second rising edge after in_rst goes high.
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
        key_debounce #(
            .DB_CYCLES  (DB_CYCLES),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_db (
            .in_clk     (in_clk),
            .in_arst_n  (in_rst),
            .in_rst_n   (rst_n),
            .key_pin    (key_in[i]),
            .key_state  (key_state[i]),
            .key_accept (accept[i])
        );
    end

    // Clear first, then set, so a set on the same edge wins.
    always_comb begin
        clr_sel   = in_clr ? in_clr_mask : '0;
        press_d   = (press_q   & ~clr_sel) | (accept & ~key_state);
        release_d = (release_q & ~clr_sel) | (accept &  key_state);
    end

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            press_q   <= '0;
            release_q <= '0;
        end else begin
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign key_press   = press_q;
    assign key_release = release_q;
    assign out_irq     = |{press_q, release_q};

endmodule : key_port
`default_nettype wire
